// File: rtl/word_serializer.sv
// word_serializer: valid/ready word in, MSB-first serial out with frame envelope and bit strobe.
// Define SER_PARITY_EN to append an even-parity bit to every frame.
module word_serializer #(
   parameter int WIDTH      = 8,
   parameter int BIT_DIV    = 1,
   parameter int GAP_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] word_in,
   input  logic             word_valid,
   output logic             word_ready,
   output logic             ser_out,
   output logic             ser_frame,
   output logic             ser_bit_stb,
   output logic             busy
);
   localparam int DW = BIT_DIV > 1 ? $clog2(BIT_DIV) : 1;
   localparam int BW = $clog2(WIDTH + 1);
   localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
`ifdef SER_PARITY_EN
      PAR,
`endif
      GAP
   } state_t;
   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [DW-1:0]    div_cnt;
   logic [BW-1:0]    bit_cnt;
   logic [GW-1:0]    gap_cnt;
   logic             last_div;
   logic             last_bit;
`ifdef SER_PARITY_EN
   logic             par;
`endif
   assign word_ready = state == IDLE;
   assign busy       = state != IDLE;
   assign last_div   = div_cnt == DW'(BIT_DIV - 1);
   assign last_bit   = bit_cnt == BW'(WIDTH - 1);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         shreg       <= '0;
         div_cnt     <= '0;
         bit_cnt     <= '0;
         gap_cnt     <= '0;
         ser_out     <= 1'b0;
         ser_frame   <= 1'b0;
         ser_bit_stb <= 1'b0;
`ifdef SER_PARITY_EN
         par         <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (word_valid) begin
               // outputs are registered, so the first bit is launched on the accepting edge
               state       <= SHIFT;
               shreg       <= word_in;
               div_cnt     <= '0;
               bit_cnt     <= '0;
               ser_out     <= word_in[WIDTH-1];
               ser_frame   <= 1'b1;
               ser_bit_stb <= 1'b1;
`ifdef SER_PARITY_EN
               par         <= ^word_in;
`endif
            end
            SHIFT: if (last_div) begin
               div_cnt <= '0;
               shreg   <= {shreg[WIDTH-2:0], 1'b0};
               bit_cnt <= bit_cnt + 1'b1;
               if (!last_bit) begin
                  ser_out     <= shreg[WIDTH-2];
                  ser_bit_stb <= 1'b1;
               end else begin
`ifdef SER_PARITY_EN
                  state       <= PAR;
                  ser_out     <= par;
                  ser_bit_stb <= 1'b1;
`else
                  state       <= GAP_CYCLES > 0 ? GAP : IDLE;
                  gap_cnt     <= '0;
                  ser_out     <= 1'b0;
                  ser_frame   <= 1'b0;
                  ser_bit_stb <= 1'b0;
`endif
               end
            end else begin
               div_cnt     <= div_cnt + 1'b1;
               ser_bit_stb <= 1'b0;
            end
`ifdef SER_PARITY_EN
            PAR: if (last_div) begin
               state       <= GAP_CYCLES > 0 ? GAP : IDLE;
               div_cnt     <= '0;
               gap_cnt     <= '0;
               ser_out     <= 1'b0;
               ser_frame   <= 1'b0;
               ser_bit_stb <= 1'b0;
            end else begin
               div_cnt     <= div_cnt + 1'b1;
               ser_bit_stb <= 1'b0;
            end
`endif
            GAP: if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= IDLE;
                 else gap_cnt <= gap_cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
